// File: rtl/pair_triple_vector_gen.sv
// pair_triple_vector_gen: streams 3-bit detector vectors with golden results and counts accepted matches
module pair_triple_vector_gen #(
  parameter int NUM_PASSES = 1,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               filter,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic               out0,
  output logic               out1,
  output logic               out2,
  output logic               expected,
  output logic               done,
  output logic [COUNT_W-1:0] match_count
);
  localparam int PW = NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t        state, state_nx;
  logic [2:0]    idx, idx_nx;
  logic [PW-1:0] pass;
  logic          filt, xfer, last_code, last_pass;
  assign {out2, out1, out0} = idx;
  assign expected  = (idx[0] & idx[1]) | (~idx[0] & ~idx[1] & idx[2]);
  assign xfer      = (state == SEND) && ostream_rdy;
  assign last_code = idx == 3'd7;
  assign last_pass = pass == PW'(NUM_PASSES - 1);
  // filtered runs step through the matching codes 3 -> 4 -> 7 only
  assign idx_nx    = filt ? (idx == 3'd3 ? 3'd4 : 3'd7) : idx + 3'd1;
  always_comb begin
    state_nx    = state;
    ostream_val = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: state_nx = start ? SEND : IDLE;
      SEND: begin
        ostream_val = 1'b1;
        state_nx    = (xfer && last_code && last_pass) ? DONE : SEND;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      pass        <= '0;
      filt        <= 1'b0;
      match_count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        filt        <= filter;
        idx         <= filter ? 3'd3 : 3'd0;
        pass        <= '0;
        match_count <= '0;
      end else if (xfer) begin
        match_count <= match_count + COUNT_W'(expected && (match_count != '1));
        if (!last_code) idx <= idx_nx;
        else if (!last_pass) begin
          pass <= pass + PW'(1);
          idx  <= filt ? 3'd3 : 3'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pair_triple_vector_gen.sv
// tb_pair_triple_vector_gen: randomized checks of three generator configurations against a queue model
module tb_pair_triple_vector_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0, filter = '0, rdy = '0;
  logic [2:0] val, done, ex;
  logic [2:0][2:0] vec;
  logic [7:0] mc [3];
  logic [7:0] mc0, mc1;
  logic [1:0] mc2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign mc[0] = mc0;
  assign mc[1] = mc1;
  assign mc[2] = {6'b0, mc2};
  pair_triple_vector_gen #(.NUM_PASSES(1), .COUNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .filter(filter[0]), .ostream_val(val[0]),
    .ostream_rdy(rdy[0]), .out0(vec[0][0]), .out1(vec[0][1]), .out2(vec[0][2]),
    .expected(ex[0]), .done(done[0]), .match_count(mc0));
  pair_triple_vector_gen #(.NUM_PASSES(2), .COUNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .filter(filter[1]), .ostream_val(val[1]),
    .ostream_rdy(rdy[1]), .out0(vec[1][0]), .out1(vec[1][1]), .out2(vec[1][2]),
    .expected(ex[1]), .done(done[1]), .match_count(mc1));
  pair_triple_vector_gen #(.NUM_PASSES(2), .COUNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .filter(filter[2]), .ostream_val(val[2]),
    .ostream_rdy(rdy[2]), .out0(vec[2][0]), .out1(vec[2][1]), .out2(vec[2][2]),
    .expected(ex[2]), .done(done[2]), .match_count(mc2));

  function automatic bit is_match(int v);
    return v == 3 || v == 4 || v == 7;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(int i, bit dn, int cnt, string tag);
    checks++;
    if (val[i] !== 1'b0 || done[i] !== dn || mc[i] !== cnt) begin
      errors++;
      $display("FAIL %s inst%0d: val=%0b done=%0b count=%0d, want val=0 done=%0b count=%0d",
               tag, i, val[i], done[i], mc[i], dn, cnt);
    end
  endtask

  task automatic run(int i, bit f, int np, int cmax, int rdy_pct);
    int q[$];
    int cnt = 0;
    int bud = 0;
    for (int p = 0; p < np; p++)
      for (int v = 0; v < 8; v++)
        if (!f || is_match(v)) q.push_back(v);
    start[i] = 1'b1;
    filter[i] = f;
    rdy[i] = 1'($urandom_range(1));
    tick();
    start[i] = 1'b0;
    while (q.size() > 0 && bud < 500) begin
      checks++;
      if (val[i] !== 1'b1 || vec[i] !== 3'(q[0]) || ex[i] !== is_match(q[0]) || done[i] !== 1'b0) begin
        errors++;
        $display("FAIL send inst%0d: val=%0b vec=%0d exp=%0b done=%0b, want val=1 vec=%0d exp=%0b done=0",
                 i, val[i], vec[i], ex[i], done[i], q[0], is_match(q[0]));
      end
      checks++;
      if (mc[i] !== cnt) begin
        errors++;
        $display("FAIL count inst%0d: got %0d want %0d", i, mc[i], cnt);
      end
      rdy[i] = 1'($urandom_range(99) < rdy_pct);
      start[i] = 1'($urandom_range(1));
      filter[i] = 1'($urandom_range(1));
      if (rdy[i]) begin
        if (is_match(q[0]) && cnt < cmax) cnt++;
        void'(q.pop_front());
      end
      tick();
      bud++;
    end
    start[i] = 1'b0;
    rdy[i] = 1'($urandom_range(1));
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout inst%0d: %0d vectors left, want 0", i, q.size());
    end
    check_idle(i, 1'b1, cnt, "done_pulse");
    tick();
    check_idle(i, 1'b0, cnt, "after_done");
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (val[i] !== 0 || vec[i] !== 0 || ex[i] !== 0 || done[i] !== 0 || mc[i] !== 0) begin
        errors++;
        $display("FAIL reset inst%0d: val=%0b vec=%0d exp=%0b done=%0b count=%0d, want all 0",
                 i, val[i], vec[i], ex[i], done[i], mc[i]);
      end
    end
  endtask

  task automatic test_stall_and_reset();
    start[0] = 1'b1;
    filter[0] = 1'b0;
    rdy[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (4) tick();
    rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[0] = 1'b1;
      tick();
      checks++;
      if (val[0] !== 1'b1 || vec[0] !== 3'd4 || ex[0] !== 1'b1 || mc[0] !== 8'd1) begin
        errors++;
        $display("FAIL stall: val=%0b vec=%0d exp=%0b count=%0d, want val=1 vec=4 exp=1 count=1",
                 val[0], vec[0], ex[0], mc[0]);
      end
    end
    start[0] = 1'b0;
    rdy[0] = 1'b1;
    tick();
    checks++;
    if (val[0] !== 1'b1 || vec[0] !== 3'd5 || mc[0] !== 8'd2) begin
      errors++;
      $display("FAIL resume: val=%0b vec=%0d count=%0d, want val=1 vec=5 count=2", val[0], vec[0], mc[0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (vec[0] !== 3'd0) begin
      errors++;
      $display("FAIL midrun_reset_vec: got %0d want 0", vec[0]);
    end
    check_idle(0, 1'b0, 0, "midrun_reset");
    tick();
    check_idle(0, 1'b0, 0, "stays_idle");
  endtask

  task automatic test_back_to_back();
    start[0] = 1'b1;
    filter[0] = 1'b1;
    rdy[0] = 1'b1;
    tick();
    repeat (3) tick();
    check_idle(0, 1'b1, 3, "b2b_done");
    tick();
    check_idle(0, 1'b0, 3, "b2b_idle");
    tick();
    checks++;
    if (val[0] !== 1'b1 || vec[0] !== 3'd3 || mc[0] !== 8'd0) begin
      errors++;
      $display("FAIL b2b_restart: val=%0b vec=%0d count=%0d, want val=1 vec=3 count=0", val[0], vec[0], mc[0]);
    end
    start[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    test_reset();
    rst = 1'b0;
    tick();
    run(0, 1'b0, 1, 255, 100);
    run(0, 1'b1, 1, 255, 100);
    test_stall_and_reset();
    for (int k = 0; k < 4; k++) run(0, 1'($urandom_range(1)), 1, 255, 50);
    run(1, 1'b1, 2, 255, 100);
    run(1, 1'b0, 2, 255, 60);
    run(2, 1'b1, 2, 3, 100);
    run(2, 1'b0, 2, 3, 70);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
